// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over a req/ack handshake and buffers up to
// two instructions for decode. Execute-stage redirects (branch or trap) flush the buffer.
module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_3000,
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_next_pc_with_delay,
  input  logic        br_enable,
  input  logic [31:0] br_target,
  input  logic [7:0]  exception,
  input  logic [31:0] exec_pc,
  output logic [31:0] epc,
  output logic [7:0]  cause,
  output logic        trap_taken
);

  typedef enum logic [1:0] {StIdle, StWait, StDrop} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] addr_q;
  logic        req_q;
  logic [31:0] epc_q;
  logic [7:0]  cause_q;
  logic        trap_q;

  logic [31:0] buf_inst_q [2];
  logic [31:0] buf_pc_q   [2];
  logic        head_q;
  logic [1:0]  count_q;

  logic        trap;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        pop;
  logic        push;
  logic        tail;
  logic [1:0]  occ_after_pop;
  logic        can_issue;

  always_comb begin
    trap          = exception != 8'h00;
    redirect      = trap | br_enable;
    redirect_pc   = trap ? TRAP_VECTOR : br_target;
    pop           = inst_valid & inst_ready;
    // A late ack arriving in StDrop belongs to the abandoned path and is never pushed.
    push          = (state_q == StWait) & imem_ack & ~redirect;
    // Only one request can be outstanding, so a push always finds count_q <= 1.
    tail          = head_q ^ count_q[0];
    occ_after_pop = count_q - {1'b0, pop};
    can_issue     = (state_q == StIdle) & ~redirect & (occ_after_pop < 2'd2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      addr_q  <= 32'h0;
      req_q   <= 1'b0;
      epc_q   <= 32'h0;
      cause_q <= 8'h00;
      trap_q  <= 1'b0;
    end else begin
      trap_q <= trap;
      if (trap) begin
        epc_q   <= exec_pc;
        cause_q <= exception;
      end
      unique case (state_q)
        StIdle: begin
          if (can_issue) begin
            req_q   <= 1'b1;
            addr_q  <= pc_q;
            state_q <= StWait;
          end
        end
        StWait: begin
          if (imem_ack) begin
            req_q   <= 1'b0;
            state_q <= StIdle;
            if (!redirect) pc_q <= pc_q + 32'd4;
          end else if (redirect) begin
            state_q <= StDrop;
          end
        end
        StDrop: begin
          if (imem_ack) begin
            req_q   <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: begin
          req_q   <= 1'b0;
          state_q <= StIdle;
        end
      endcase
      // Redirect overrides any sequential PC advance above.
      if (redirect) pc_q <= redirect_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || redirect) begin
      head_q  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_q ^ pop;
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_inst_q[tail] <= imem_data;
      buf_pc_q[tail]   <= pc_q;
    end
  end

  always_comb begin
    imem_req   = req_q;
    imem_addr  = addr_q;
    epc        = epc_q;
    cause      = cause_q;
    trap_taken = trap_q;
    inst_valid = count_q != 2'd0;
    if (inst_valid) begin
      inst                    = buf_inst_q[head_q];
      inst_pc                 = buf_pc_q[head_q];
      inst_next_pc_with_delay = buf_pc_q[head_q] + 32'd8;
    end else begin
      inst                    = 32'h0;
      inst_pc                 = 32'h0;
      inst_next_pc_with_delay = 32'h0;
    end
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage and PC owner for the pipelined MIPS core.
- Receives redirects from the execute-stage ALU (br_enable/br_target, exception) and fetches from instruction memory with a req/ack handshake.
- Buffers up to 2 fetched instructions for decode.
- Supplies each instruction with its PC and the ALU's next_pc_with_delay operand, which equals PC+8.

Parameters:
- RESET_PC, 32'h0000_3000, first fetch address after reset.
- TRAP_VECTOR, 32'h0000_4180, fetch address on any nonzero exception.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- imem_req  output  1  fetch request.
- imem_addr  output  32  fetch address, word aligned.
- imem_ack  input  1  request accepted; imem_data valid this cycle.
- imem_data  input  32  instruction word.
- inst_valid  output  1  buffer head valid.
- inst_ready  input  1  decode accepts head.
- inst  output  32  head instruction.
- inst_pc  output  32  head PC.
- inst_next_pc_with_delay  output  32  head PC + 8, drives ALU next_pc_with_delay.
- br_enable  input  1  execute redirect request.
- br_target  input  32  redirect address.
- exception  input  8  execute trap code; 0 means none.
- exec_pc  input  32  PC of the instruction currently in execute.
- epc  output  32  PC of last trapping instruction.
- cause  output  8  code of last trap.
- trap_taken  output  1  one-cycle pulse when a trap redirect is applied.

Behaviour:
- Reset, synchronous (rst high at edge):
  - pc=RESET_PC; buffer emptied; state IDLE.
  - imem_req=0, inst_valid=0, epc=0, cause=0, trap_taken=0.
  - inst, inst_pc and inst_next_pc_with_delay read 0 while empty.
  - Reset mid-request abandons the request: imem_req drops the cycle after the edge, and any ack that follows is ignored because state is IDLE.
- Buffer: 2-entry FIFO of {inst, pc}. Head drives the outputs; pop on inst_valid & inst_ready. Push and pop may occur in the same cycle.
- Request handshake:
  - While imem_req=1, imem_addr is held stable until imem_ack.
  - At most one request outstanding.
  - Data is captured on the ack cycle and visible as inst_valid the next cycle.
- Issue rule: imem_req may be asserted only when (occupancy − pop this cycle) + outstanding < 2. A full buffer with no pop produces no request.
- State machine:
  - IDLE: if the issue rule allows, assert imem_req with addr=pc and go to WAIT.
  - WAIT, imem_ack and no redirect: push {imem_data, pc}; pc += 4; go to IDLE.
  - The next request may issue the cycle after the ack, giving 1 instruction per 2 cycles minimum with a 1-cycle ack.
  - WAIT, redirect without ack: go to DROP; imem_req and imem_addr stay held.
  - WAIT, redirect with ack in the same cycle: the data is discarded; go to IDLE.
  - DROP, imem_ack: discard data; go to IDLE.
- Redirect (sampled each cycle; exception takes priority over br_enable):
  - Exception nonzero:
    - pc=TRAP_VECTOR, epc=exec_pc, cause=exception.
    - trap_taken=1 for the next cycle only.
    - Buffer flushed; a same-cycle pop is irrelevant.
  - Else br_enable: pc=br_target; buffer flushed.
  - The first fetch of the new pc issues the cycle after the redirect if the state becomes IDLE.
  - inst_valid is 0 from the cycle after the redirect until the new instruction arrives.
- Arithmetic: pc+4 and pc+8 wrap modulo 2^32; no alignment check on br_target (low 2 bits passed through).
- Simultaneous push and flush: flush wins and the pushed data is discarded.

Test Plan:
1. Reset release, imem_ack always 1, inst_ready=1 → imem_addr sequence 0x3000, 0x3004, 0x3008 on alternate cycles; inst_next_pc_with_delay=0x3008 for inst_pc=0x3000.
2. inst_ready=0, ack always 1 → exactly 2 entries fetched (0x3000, 0x3004), imem_req stays 0, inst holds the 0x3000 word. Raising inst_ready resumes fetch at 0x3008.
3. br_enable=1, br_target=0x3100 while buffer holds 2 entries → inst_valid=0 next cycle; next imem_addr=0x3100; old entries never presented.
4. Redirect to 0x3200 while a request for 0x3008 waits 3 cycles for ack → 0x3008 held until ack and its data dropped; next request is 0x3200.
5. exception=8'h0C, br_enable=1, exec_pc=0x3010 in the same cycle → pc=0x4180, epc=0x3010, cause=0x0C, trap_taken high exactly 1 cycle.
6. rst asserted mid-WAIT, then ack arrives → ack ignored, first post-reset addr=0x3000, inst_valid=0.
